prga_check: RTL and testbench

PRGA_CHECK -- requirements
Module: prga_check

---
 rtl/prga_check.sv | 246 ++++++++++++++++++++++++
 tb/tb_prga_check.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/prga_check.sv
// prga_check: RC4 PRGA decryptor that rebuilds plaintext from a length-prefixed
// ciphertext ROM and reports whether every plaintext byte is printable ASCII.
// Optional macro PRGA_DROP_EN adds a DROP_N-byte keystream discard phase.
module prga_check #(
    parameter int unsigned AW          = 8,
    parameter int unsigned EARLY_ABORT = 0,
    parameter int unsigned DROP_N      = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          rdy,
    output logic          key_valid,
    output logic [7:0]    s_addr,
    output logic [7:0]    s_wrdata,
    input  logic [7:0]    s_rddata,
    output logic          s_wren,
    output logic [AW-1:0] ct_addr,
    input  logic [7:0]    ct_rddata,
    output logic [AW-1:0] pt_addr,
    output logic [7:0]    pt_wrdata,
    output logic          pt_wren
);

    localparam int unsigned DCW = 10;

    // Reject out-of-range configurations at elaboration
    if (AW < 8 || AW > 12 || DROP_N > 1023) begin : g_param_err
        $error("prga_check: AW must be 8..12 and DROP_N 0..1023");
    end

    typedef enum logic [3:0] {
        IDLE, RD_LEN, WAIT_LEN, WR_LEN, RD_SI, WAIT_SI, RD_SJ,
        WAIT_SJ, WR_SI, WR_SJ, RD_PAD, WAIT_PAD, WR_PT
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
    logic [7:0]    si_q, si_d, sj_q, sj_d;
    logic          fail_q, fail_d, rdy_q, rdy_d, key_valid_q, key_valid_d;
    logic [7:0]    s_addr_q, s_addr_d, s_wrdata_q, s_wrdata_d;
    logic          s_wren_q, s_wren_d, pt_wren_q, pt_wren_d;
    logic [AW-1:0] ct_addr_q, ct_addr_d, pt_addr_q, pt_addr_d;
    logic [7:0]    pt_wrdata_q, pt_wrdata_d;
    logic          pt_printable_c;
`ifdef PRGA_DROP_EN
    logic [DCW-1:0] drop_cnt_q, drop_cnt_d;
    logic           dropping_c;
    assign dropping_c = (drop_cnt_q != '0);
`endif

    assign pt_printable_c = (pt_wrdata_q >= 8'h20) && (pt_wrdata_q <= 8'h7E);

    // Next-state and next-output logic; outputs are registered from *_d
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        len_d       = len_q;
        si_d        = si_q;
        sj_d        = sj_q;
        fail_d      = fail_q;
        rdy_d       = rdy_q;
        key_valid_d = key_valid_q;
        s_addr_d    = s_addr_q;
        s_wrdata_d  = s_wrdata_q;
        s_wren_d    = 1'b0;
        ct_addr_d   = ct_addr_q;
        pt_addr_d   = pt_addr_q;
        pt_wrdata_d = pt_wrdata_q;
        pt_wren_d   = 1'b0;
`ifdef PRGA_DROP_EN
        drop_cnt_d  = drop_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d     = RD_LEN;
                    rdy_d       = 1'b0;
                    key_valid_d = 1'b0;
                    fail_d      = 1'b0;
                    i_d         = 8'd0;
                    j_d         = 8'd0;
                    k_d         = 8'd0;
                    ct_addr_d   = '0;
                end
            end
            RD_LEN:   state_d = WAIT_LEN;
            WAIT_LEN: begin
                len_d       = ct_rddata;
                pt_addr_d   = '0;
                pt_wrdata_d = ct_rddata;
                pt_wren_d   = 1'b1;
                state_d     = WR_LEN;
            end
            WR_LEN: begin
`ifdef PRGA_DROP_EN
                if (DROP_N != 0) begin
                    drop_cnt_d = DCW'(DROP_N);
                    k_d        = (len_q == 8'd0) ? 8'd0 : 8'd1;
                    i_d        = i_q + 8'd1;
                    s_addr_d   = i_q + 8'd1;
                    state_d    = RD_SI;
                end else
`endif
                if (len_q == 8'd0) begin
                    rdy_d       = 1'b1;
                    key_valid_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    k_d      = 8'd1;
                    i_d      = i_q + 8'd1;
                    s_addr_d = i_q + 8'd1;
                    state_d  = RD_SI;
                end
            end
            RD_SI:   state_d = WAIT_SI;
            WAIT_SI: begin
                si_d     = s_rddata;
                j_d      = j_q + s_rddata;
                s_addr_d = j_q + s_rddata;
                state_d  = RD_SJ;
            end
            RD_SJ:   state_d = WAIT_SJ;
            WAIT_SJ: begin
                sj_d       = s_rddata;
                s_addr_d   = i_q;
                s_wrdata_d = s_rddata;
                s_wren_d   = 1'b1;
                state_d    = WR_SI;
            end
            WR_SI: begin
                s_addr_d   = j_q;
                s_wrdata_d = si_q;
                s_wren_d   = 1'b1;
                state_d    = WR_SJ;
            end
            WR_SJ: begin
                s_addr_d = si_q + sj_q;
`ifdef PRGA_DROP_EN
                if (!dropping_c) ct_addr_d = AW'(k_q);
`else
                ct_addr_d = AW'(k_q);
`endif
                state_d  = RD_PAD;
            end
            RD_PAD:  state_d = WAIT_PAD;
            WAIT_PAD: begin
`ifdef PRGA_DROP_EN
                if (dropping_c) begin
                    drop_cnt_d = drop_cnt_q - DCW'(1);
                    if (drop_cnt_q == DCW'(1) && len_q == 8'd0) begin
                        rdy_d       = 1'b1;
                        key_valid_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        i_d      = i_q + 8'd1;
                        s_addr_d = i_q + 8'd1;
                        state_d  = RD_SI;
                    end
                end else
`endif
                begin
                    pt_addr_d   = AW'(k_q);
                    pt_wrdata_d = ct_rddata ^ s_rddata;
                    pt_wren_d   = 1'b1;
                    state_d     = WR_PT;
                end
            end
            WR_PT: begin
                fail_d = fail_q | ~pt_printable_c;
                if (k_q == len_q || (EARLY_ABORT != 0 && !pt_printable_c)) begin
                    rdy_d       = 1'b1;
                    key_valid_d = ~fail_d;
                    state_d     = IDLE;
                end else begin
                    k_d      = k_q + 8'd1;
                    i_d      = i_q + 8'd1;
                    s_addr_d = i_q + 8'd1;
                    state_d  = RD_SI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            k_q         <= 8'd0;
            len_q       <= 8'd0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            fail_q      <= 1'b0;
            rdy_q       <= 1'b1;
            key_valid_q <= 1'b0;
            s_addr_q    <= 8'd0;
            s_wrdata_q  <= 8'd0;
            s_wren_q    <= 1'b0;
            ct_addr_q   <= '0;
            pt_addr_q   <= '0;
            pt_wrdata_q <= 8'd0;
            pt_wren_q   <= 1'b0;
`ifdef PRGA_DROP_EN
            drop_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            len_q       <= len_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            fail_q      <= fail_d;
            rdy_q       <= rdy_d;
            key_valid_q <= key_valid_d;
            s_addr_q    <= s_addr_d;
            s_wrdata_q  <= s_wrdata_d;
            s_wren_q    <= s_wren_d;
            ct_addr_q   <= ct_addr_d;
            pt_addr_q   <= pt_addr_d;
            pt_wrdata_q <= pt_wrdata_d;
            pt_wren_q   <= pt_wren_d;
`ifdef PRGA_DROP_EN
            drop_cnt_q  <= drop_cnt_d;
`endif
        end
    end

    assign rdy       = rdy_q;
    assign key_valid = key_valid_q;
    assign s_addr    = s_addr_q;
    assign s_wrdata  = s_wrdata_q;
    assign ct_addr   = ct_addr_q;
    assign pt_addr   = pt_addr_q;
    assign pt_wrdata = pt_wrdata_q;
    // Write enables are masked by rst so a reset cycle can never commit a write
    assign s_wren    = s_wren_q & ~rst;
    assign pt_wren   = pt_wren_q & ~rst;

endmodule

// File: tb/tb_prga_check.sv
// Directed bench for prga_check: instance 0 runs to completion, instance 1 has
// EARLY_ABORT=1. Both use DROP_N=1 so a PRGA_DROP_EN build has short runs.
module tb_prga_check;

    logic       clk = 1'b0;
    logic       rst;
    logic       en        [2];
    logic       rdy       [2];
    logic       kv        [2];
    logic [7:0] s_addr    [2];
    logic [7:0] s_wrdata  [2];
    logic [7:0] s_rddata  [2];
    logic       s_wren    [2];
    logic [7:0] ct_addr   [2];
    logic [7:0] ct_rddata [2];
    logic [7:0] pt_addr   [2];
    logic [7:0] pt_wrdata [2];
    logic       pt_wren   [2];

    logic [7:0] s_mem   [2][256];
    logic [7:0] ct_mem  [2][256];
    logic [7:0] pt_mem  [2][256];
    int         pt_wcnt [2][256];
    int         s_wcnt  [2];
    logic       init_req[2];
    int         rst_wr_viol  = 0;
    int         dual_wr_viol = 0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prga_check #(.AW(8), .EARLY_ABORT(0), .DROP_N(1)) u_dut0 (
        .clk(clk), .rst(rst), .en(en[0]), .rdy(rdy[0]), .key_valid(kv[0]),
        .s_addr(s_addr[0]), .s_wrdata(s_wrdata[0]), .s_rddata(s_rddata[0]),
        .s_wren(s_wren[0]), .ct_addr(ct_addr[0]), .ct_rddata(ct_rddata[0]),
        .pt_addr(pt_addr[0]), .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0])
    );

    prga_check #(.AW(8), .EARLY_ABORT(1), .DROP_N(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en[1]), .rdy(rdy[1]), .key_valid(kv[1]),
        .s_addr(s_addr[1]), .s_wrdata(s_wrdata[1]), .s_rddata(s_rddata[1]),
        .s_wren(s_wren[1]), .ct_addr(ct_addr[1]), .ct_rddata(ct_rddata[1]),
        .pt_addr(pt_addr[1]), .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1])
    );

    // Memory models: 1-cycle read latency, write on enable, plus illegal-write monitors
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst && (s_wren[u] || pt_wren[u])) rst_wr_viol <= rst_wr_viol + 1;
            if (s_wren[u] && pt_wren[u]) dual_wr_viol <= dual_wr_viol + 1;
            s_rddata[u]  <= s_mem[u][s_addr[u]];
            ct_rddata[u] <= ct_mem[u][ct_addr[u]];
            if (init_req[u]) begin
                for (int a = 0; a < 256; a++) begin
                    s_mem[u][a]   <= 8'(a);
                    pt_mem[u][a]  <= 8'h00;
                    pt_wcnt[u][a] <= 0;
                end
                s_wcnt[u] <= 0;
            end else begin
                if (s_wren[u]) begin
                    s_mem[u][s_addr[u]] <= s_wrdata[u];
                    s_wcnt[u] <= s_wcnt[u] + 1;
                end
                if (pt_wren[u]) begin
                    pt_mem[u][pt_addr[u]]  <= pt_wrdata[u];
                    pt_wcnt[u][pt_addr[u]] <= pt_wcnt[u][pt_addr[u]] + 1;
                end
            end
        end
    end

    typedef struct {
        int         u;
        logic [7:0] ct0, ct1, ct2;
        logic [7:0] p0, p1, p2;
        bit         p2wr;
        bit         kv;
        int         cyc;
        int         sw;
        logic [7:0] s2, s3;
        bit         poke;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic prep(input int u, input logic [7:0] c0, input logic [7:0] c1,
                        input logic [7:0] c2);
        ct_mem[u][0] = c0;
        ct_mem[u][1] = c1;
        ct_mem[u][2] = c2;
        @(posedge clk); #1;
        init_req[u] = 1'b1;
        @(posedge clk); #1;
        init_req[u] = 1'b0;
    endtask

    // Start a run and count cycles from the accepting edge until rdy returns
    task automatic do_run(input int u, input bit poke, output int cyc, output bit tmo);
        @(posedge clk); #1;
        en[u] = 1'b1;
        @(posedge clk); #1;
        en[u] = 1'b0;
        cyc = 0;
        tmo = 1'b1;
        for (int c = 1; c <= 2000; c++) begin
            en[u] = poke && (c == 6);
            @(posedge clk); #1;
            if (rdy[u]) begin
                cyc = c;
                tmo = 1'b0;
                break;
            end
        end
        en[u] = 1'b0;
    endtask

    initial begin
        int  cyc;
        bit  tmo;
        logic [7:0] e1, e2;

        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            en[u]       = 1'b0;
            init_req[u] = 1'b0;
        end
        for (int u = 0; u < 2; u++)
            for (int a = 0; a < 256; a++) ct_mem[u][a] = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", int'(rdy[0]), 1);
        check("rst_kv", int'(kv[0]), 0);
        check("rst_s_wren", int'(s_wren[0]), 0);
        check("rst_pt_wren", int'(pt_wren[0]), 0);
        check("rst_s_addr", int'(s_addr[0]), 0);
        check("rst_ct_addr", int'(ct_addr[0]), 0);
        check("rst_pt_addr", int'(pt_addr[1]), 0);
        rst = 1'b0;

        //          u  ct0    ct1    ct2    p0     p1     p2    p2wr kv cyc sw s2    s3    poke
`ifdef PRGA_DROP_EN
        vecs.push_back('{0, 8'h01, 8'h41, 8'h00, 8'h01, 8'h44, 8'h00, 0, 1, 20, 4, 8'h03, 8'h02, 1});
        vecs.push_back('{0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 11, 2, 8'h02, 8'h03, 0});
        vecs.push_back('{1, 8'h01, 8'h02, 8'h00, 8'h01, 8'h07, 8'h00, 0, 0, 20, 4, 8'h03, 8'h02, 1});
        vecs.push_back('{0, 8'h02, 8'h41, 8'h42, 8'h02, 8'h44, 8'h45, 1, 1, 29, 6, 8'h03, 8'h05, 1});
`else
        vecs.push_back('{0, 8'h02, 8'h41, 8'h42, 8'h02, 8'h43, 8'h47, 1, 1, 21, 4, 8'h03, 8'h02, 1});
        vecs.push_back('{0, 8'h01, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 0, 0, 12, 2, 8'h02, 8'h03, 1});
        vecs.push_back('{1, 8'h02, 8'h02, 8'h41, 8'h02, 8'h00, 8'h00, 0, 0, 12, 2, 8'h02, 8'h03, 1});
        vecs.push_back('{0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1,  3, 0, 8'h02, 8'h03, 0});
        vecs.push_back('{1, 8'h02, 8'h41, 8'h42, 8'h02, 8'h43, 8'h47, 1, 1, 21, 4, 8'h03, 8'h02, 1});
        vecs.push_back('{0, 8'h02, 8'h7C, 8'h7B, 8'h02, 8'h7E, 8'h7E, 1, 1, 21, 4, 8'h03, 8'h02, 0});
        vecs.push_back('{0, 8'h02, 8'h22, 8'h25, 8'h02, 8'h20, 8'h20, 1, 1, 21, 4, 8'h03, 8'h02, 0});
        vecs.push_back('{0, 8'h02, 8'h41, 8'h04, 8'h02, 8'h43, 8'h01, 1, 0, 21, 4, 8'h03, 8'h02, 0});
        vecs.push_back('{0, 8'h02, 8'h7D, 8'h41, 8'h02, 8'h7F, 8'h44, 1, 0, 21, 4, 8'h03, 8'h02, 1});
        vecs.push_back('{1, 8'h02, 8'h7D, 8'h41, 8'h02, 8'h7F, 8'h00, 0, 0, 12, 2, 8'h02, 8'h03, 1});
        vecs.push_back('{0, 8'h01, 8'h1D, 8'h00, 8'h01, 8'h1F, 8'h00, 0, 0, 12, 2, 8'h02, 8'h03, 0});
`endif

        foreach (vecs[i]) begin
            vec_t v;
            int   u;
            v = vecs[i];
            u = v.u;
            prep(u, v.ct0, v.ct1, v.ct2);
            do_run(u, v.poke, cyc, tmo);
            check($sformatf("v%0d_timeout", i), int'(tmo), 0);
            check($sformatf("v%0d_cycles", i), cyc, v.cyc);
            check($sformatf("v%0d_kv", i), int'(kv[u]), int'(v.kv));
            check($sformatf("v%0d_pt0", i), int'(pt_mem[u][0]), int'(v.p0));
            check($sformatf("v%0d_pt1", i), int'(pt_mem[u][1]), int'(v.p1));
            check($sformatf("v%0d_pt2", i), int'(pt_mem[u][2]), int'(v.p2));
            check($sformatf("v%0d_pt2_wcnt", i), pt_wcnt[u][2], int'(v.p2wr));
            check($sformatf("v%0d_s_writes", i), s_wcnt[u], v.sw);
            check($sformatf("v%0d_s2", i), int'(s_mem[u][2]), int'(v.s2));
            check($sformatf("v%0d_s3", i), int'(s_mem[u][3]), int'(v.s3));
            // Still idle one cycle later: busy en pulse must not have queued a run
            @(posedge clk); #1;
            check($sformatf("v%0d_idle_after", i), int'(rdy[u]), 1);
        end

        // Reset 20 cycles into a run aborts it without any write while rst=1
        prep(0, 8'h02, 8'h41, 8'h42);
        @(posedge clk); #1;
        en[0] = 1'b1;
        @(posedge clk); #1;
        en[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_busy", int'(rdy[0]), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_rdy", int'(rdy[0]), 1);
        check("midrst_kv", int'(kv[0]), 0);
        @(posedge clk); #1;
        check("midrst_rdy_hold", int'(rdy[0]), 1);
        rst = 1'b0;
        check("midrst_pt2_unwritten", pt_wcnt[0][2], 0);
        check("rst_write_violations", rst_wr_viol, 0);

        // First run after reset completes normally
`ifdef PRGA_DROP_EN
        e1 = 8'h44;
        e2 = 8'h45;
`else
        e1 = 8'h43;
        e2 = 8'h47;
`endif
        prep(0, 8'h02, 8'h41, 8'h42);
        do_run(0, 1'b0, cyc, tmo);
        check("rerun_timeout", int'(tmo), 0);
        check("rerun_kv", int'(kv[0]), 1);
        check("rerun_pt0", int'(pt_mem[0][0]), 8'h02);
        check("rerun_pt1", int'(pt_mem[0][1]), int'(e1));
        check("rerun_pt2", int'(pt_mem[0][2]), int'(e2));

        check("dual_write_violations", dual_wr_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
